// File: rtl/dsc_pkg.sv
// -----------------------------------------------------------------------------
// dsc_pkg
// Shared definitions for the DSC stream decoder: the decoder FSM state
// encoding, the default result width and the shortest legal window length.
// No ports (package).
// -----------------------------------------------------------------------------
package dsc_pkg;

  // Default width of the decoded binary result.
  localparam int DSC_DATA_WIDTH = 8;

  // Shortest window the decoder can run: a window always samples at least
  // one bit because cyc_limit=0 selects the full-length window.
  localparam int MIN_CYC_DSC = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } dsc_state_e;

endpackage

// File: rtl/dsc_stream_decoder_if.sv
// -----------------------------------------------------------------------------
// dsc_stream_decoder_if
// Bundles the request side (en, start, stream_in, cyc_limit, out_ready) and
// the result side (bin_data_out, cycle_count, busy, op_finished, out_valid)
// of the DSC stream decoder.
//   master : drives the request side, observes the result side
//   slave  : the decoder itself
// -----------------------------------------------------------------------------
interface dsc_stream_decoder_if
  import dsc_pkg::*;
#(
  parameter int DATA_WIDTH = DSC_DATA_WIDTH
);

  logic                  en;
  logic                  start;
  logic                  stream_in;
  logic [DATA_WIDTH-1:0] cyc_limit;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] bin_data_out;
  logic [DATA_WIDTH:0]   cycle_count;
  logic                  busy;
  logic                  op_finished;
  logic                  out_valid;

  modport master (
    output en, start, stream_in, cyc_limit, out_ready,
    input  bin_data_out, cycle_count, busy, op_finished, out_valid
  );

  modport slave (
    input  en, start, stream_in, cyc_limit, out_ready,
    output bin_data_out, cycle_count, busy, op_finished, out_valid
  );

endinterface

// File: rtl/dsc_stream_decoder_counter.sv
// -----------------------------------------------------------------------------
// dsc_stream_decoder_counter
// Free-running up counter with asynchronous reset, synchronous clear and
// count enable. Clear has priority over enable.
//   clk_i   : clock
//   rst_i   : asynchronous active-high reset
//   clr_i   : synchronous clear to zero
//   en_i    : advance by STRIDE on this edge
//   count_o : current count
// -----------------------------------------------------------------------------
module dsc_stream_decoder_counter
  import dsc_pkg::*;
#(
  parameter int WIDTH  = DSC_DATA_WIDTH + 1,
  parameter int STRIDE = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(STRIDE);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dsc_stream_decoder.sv
// -----------------------------------------------------------------------------
// dsc_stream_decoder
// Converts a unary/temporal DSC bitstream into a binary ones-count. A start
// in IDLE opens a window of L sampled cycles (L = cyc_limit, or MAX_CYC when
// cyc_limit is 0). Every enabled cycle adds stream_in to a saturating
// accumulator; when the L-th sample is taken the total is registered, a
// one-cycle op_finished pulse is raised and the result is held (out_valid)
// until the consumer accepts it with out_ready.
//   gclk : system clock (rising edge)
//   rst  : asynchronous active-high reset
//   bus  : request/result bundle, slave side
//          en, start, stream_in, cyc_limit, out_ready -> in
//          bin_data_out, cycle_count, busy, op_finished, out_valid -> out
// -----------------------------------------------------------------------------
module dsc_stream_decoder
  import dsc_pkg::*;
#(
  parameter int DATA_WIDTH = DSC_DATA_WIDTH,
  parameter int MAX_CYC    = 2**DATA_WIDTH - 1
) (
  input  logic                gclk,
  input  logic                rst,
  dsc_stream_decoder_if.slave bus
);

  localparam int CNT_W = DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] ACC_MAX = '1;

  // Adds one stream bit to the accumulator, pinning at all-ones.
  function automatic logic [DATA_WIDTH-1:0] sat_add_bit(
    input logic [DATA_WIDTH-1:0] acc,
    input logic                  bit_in
  );
    if (bit_in && (acc != ACC_MAX)) begin
      return acc + 1'b1;
    end
    return acc;
  endfunction

  dsc_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]      lim_q, lim_d;
  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic                  fin_q, fin_d;

  logic [CNT_W-1:0]      cnt;
  logic                  start_idle;
  logic                  sample;
  logic                  close;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [CNT_W-1:0]      lim_sel;

  assign start_idle = (state_q == IDLE) && bus.start;
  assign sample     = (state_q == COUNT) && bus.en;
  assign acc_next   = sat_add_bit(acc_q, bus.stream_in);
  assign lim_sel    = (bus.cyc_limit == '0) ? CNT_W'(MAX_CYC) : CNT_W'(bus.cyc_limit);
  // The window closes on the edge that takes the L-th sample, so compare the
  // count this edge will produce rather than the current one.
  assign close      = sample && ((cnt + CNT_W'(1)) == lim_q);

  dsc_stream_decoder_counter #(
    .WIDTH  (CNT_W),
    .STRIDE (1)
  ) u_cycle_cnt (
    .clk_i   (gclk),
    .rst_i   (rst),
    .clr_i   (rst | start_idle),
    .en_i    (bus.busy & bus.en),
    .count_o (cnt)
  );

  // FSM: state register
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start)     state_d = COUNT;
      COUNT:   if (close)         state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy      = (state_q == COUNT);
    bus.out_valid = (state_q == HOLD);
  end

  // Accumulator, latched limit and result registers
  always_comb begin
    acc_d = acc_q;
    lim_d = lim_q;
    bin_d = bin_q;
    fin_d = 1'b0;
    if (start_idle) begin
      acc_d = '0;
      lim_d = lim_sel;
    end else if (sample) begin
      acc_d = acc_next;
      if (close) begin
        bin_d = acc_next;
        fin_d = 1'b1;
      end
    end
  end

  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      lim_q <= '0;
      bin_q <= '0;
      fin_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      lim_q <= lim_d;
      bin_q <= bin_d;
      fin_q <= fin_d;
    end
  end

  assign bus.bin_data_out = bin_q;
  assign bus.cycle_count  = cnt;
  assign bus.op_finished  = fin_q;

endmodule

// File: tb/tb_dsc_stream_decoder.sv
// -----------------------------------------------------------------------------
// tb_dsc_stream_decoder
// Directed table of decode windows with hand-computed results, a reset
// mid-window sequence, and randomly generated windows checked against a
// ones-count scoreboard.
// -----------------------------------------------------------------------------
module tb_dsc_stream_decoder;
  import dsc_pkg::*;

  typedef struct {
    int lim;       // cyc_limit driven at start
    int pat;       // 0 ones, 1 first prm ones, 2 alternating, 3 zeros, 4 random
    int prm;
    int tog;       // 1: en toggles 1/0 starting with 1 on the start edge
    int hold;      // cycles out_ready stays low after close (start pulsed)
    int exp_bin;   // -1: take from scoreboard
    int exp_cnt;
    int exp_edge;  // edge index (start edge = 0) where the window closes
  } vec_t;

  logic gclk;
  logic rst;
  int   total;
  int   bad;

  dsc_stream_decoder_if #(.DATA_WIDTH(8)) bus ();

  dsc_stream_decoder #(.DATA_WIDTH(8)) dut (
    .gclk (gclk),
    .rst  (rst),
    .bus  (bus)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic pat_bit(input int pat, input int prm, input int k);
    case (pat)
      0:       return 1'b1;
      1:       return (k < prm);
      2:       return (k % 2 == 0);
      3:       return 1'b0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic run_window(input vec_t v, input string tag, output int cnt_seen);
    int   ones;
    int   k;
    int   close_e;
    int   exp_bin;
    logic s;
    logic en_now;
    ones     = 0;
    k        = 0;
    close_e  = -1;
    cnt_seen = 0;
    s        = 1'b0;

    bus.cyc_limit = 8'(v.lim);
    bus.out_ready = (v.hold == 0);
    bus.en        = 1'b1;
    bus.stream_in = 1'b0;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    check($sformatf("%s busy_open", tag), 32'(bus.busy), 1);
    check($sformatf("%s cnt_cleared", tag), 32'(bus.cycle_count), 0);

    for (int e = 1; e <= 600; e++) begin
      en_now = (v.tog != 0) ? (e % 2 == 0) : 1'b1;
      bus.en = en_now;
      if (en_now) begin
        s = pat_bit(v.pat, v.prm, k);
        k++;
        ones += int'(s);
      end else begin
        s = 1'b1;  // must be ignored while en is low
      end
      bus.stream_in = s;
      step();
      if (bus.op_finished === 1'b1) begin
        close_e = e;
        break;
      end
    end
    bus.en        = 1'b1;
    bus.stream_in = 1'b0;

    if (close_e < 0) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no op_finished in 600 edges, want edge %0d", tag, v.exp_edge);
      return;
    end

    exp_bin = (v.exp_bin < 0) ? ones : v.exp_bin;
    check($sformatf("%s close_edge", tag), close_e, v.exp_edge);
    check($sformatf("%s bin", tag), 32'(bus.bin_data_out), exp_bin);
    check($sformatf("%s cnt", tag), 32'(bus.cycle_count), v.exp_cnt);
    check($sformatf("%s valid_at_close", tag), 32'(bus.out_valid), 1);
    check($sformatf("%s busy_at_close", tag), 32'(bus.busy), 0);
    cnt_seen = int'(bus.cycle_count);

    for (int h = 0; h < v.hold; h++) begin
      bus.out_ready = 1'b0;
      bus.start     = 1'b1;
      step();
      check($sformatf("%s hold%0d valid", tag, h), 32'(bus.out_valid), 1);
      check($sformatf("%s hold%0d bin", tag, h), 32'(bus.bin_data_out), exp_bin);
      check($sformatf("%s hold%0d fin", tag, h), 32'(bus.op_finished), 0);
      check($sformatf("%s hold%0d busy", tag, h), 32'(bus.busy), 0);
    end

    bus.out_ready = 1'b1;
    bus.start     = (v.hold > 0);
    step();
    bus.start = 1'b0;
    check($sformatf("%s fin_one_cycle", tag), 32'(bus.op_finished), 0);
    check($sformatf("%s valid_dropped", tag), 32'(bus.out_valid), 0);
    check($sformatf("%s cnt_held", tag), 32'(bus.cycle_count), v.exp_cnt);
    step();
    check($sformatf("%s stays_idle", tag), 32'(bus.busy), 0);
  endtask

  vec_t vecs[10];
  vec_t rv;
  int   seen;
  int   cnt_sum;
  int   fin_seen;
  int   lim;

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{0,   1, 100, 0, 0, 100, 255, 255};
    vecs[1] = '{16,  0, 0,   0, 0, 16,  16,  16};
    vecs[2] = '{10,  0, 0,   1, 0, 10,  10,  20};
    vecs[3] = '{1,   0, 0,   0, 0, 1,   1,   1};
    vecs[4] = '{1,   3, 0,   0, 0, 0,   1,   1};
    vecs[5] = '{7,   2, 0,   0, 0, 4,   7,   7};
    vecs[6] = '{255, 0, 0,   0, 0, 255, 255, 255};
    vecs[7] = '{9,   3, 0,   1, 0, 0,   9,   18};
    vecs[8] = '{3,   1, 5,   0, 0, 3,   3,   3};
    vecs[9] = '{4,   0, 0,   0, 5, 4,   4,   4};

    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.start     = 1'b0;
    bus.stream_in = 1'b0;
    bus.cyc_limit = '0;
    bus.out_ready = 1'b0;
    #12;
    check("reset busy", 32'(bus.busy), 0);
    check("reset valid", 32'(bus.out_valid), 0);
    check("reset fin", 32'(bus.op_finished), 0);
    check("reset bin", 32'(bus.bin_data_out), 0);
    check("reset cnt", 32'(bus.cycle_count), 0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 10; i++) begin
      run_window(vecs[i], $sformatf("vec%0d", i), seen);
    end

    // Asynchronous reset part-way through a 20-cycle window.
    bus.cyc_limit = 8'd20;
    bus.out_ready = 1'b1;
    bus.en        = 1'b1;
    bus.stream_in = 1'b1;
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    for (int e = 1; e <= 7; e++) step();
    check("rst_mid cnt_before", 32'(bus.cycle_count), 7);
    #3 rst = 1'b1;
    #1;
    check("rst_mid busy", 32'(bus.busy), 0);
    check("rst_mid valid", 32'(bus.out_valid), 0);
    check("rst_mid fin", 32'(bus.op_finished), 0);
    check("rst_mid bin", 32'(bus.bin_data_out), 0);
    check("rst_mid cnt", 32'(bus.cycle_count), 0);
    step();
    rst = 1'b0;
    fin_seen = 0;
    for (int e = 0; e < 30; e++) begin
      step();
      if (bus.op_finished !== 1'b0) fin_seen++;
    end
    check("rst_mid no_fin_pulse", fin_seen, 0);
    rv = '{20, 0, 0, 0, 0, 20, 20, 20};
    run_window(rv, "after_rst", seen);

    // Random windows against the ones-count scoreboard.
    cnt_sum = 0;
    for (int r = 0; r < 200; r++) begin
      lim = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      rv  = '{lim, 4, 0, 0, 0, -1, (lim == 0) ? 255 : lim, (lim == 0) ? 255 : lim};
      run_window(rv, $sformatf("rnd%0d", r), seen);
      cnt_sum += seen;
    end
    $display("random windows: average cycle_count = %0d", cnt_sum / 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
